frame_tx_1101: RTL

Serial frame transmitter that sends a `1101` preamble, then a parallel payload word, over a single-bit line. It is the sending end of the `1101` sequence-detector link. Its serial output drives the detector's `x` input, so the detector pulses on the final preamble bit of each frame. The block accepts one word per valid/ready handshake and guarantees a minimum run of zeros between frames.

---
 rtl/frame_1101_pkg.sv | 14 +
 rtl/frame_tx_1101_piso_shift.sv | 28 ++
 rtl/frame_tx_1101.sv | 119 +++++++++++
 3 files changed

// File: rtl/frame_1101_pkg.sv
// Shared constants and state encoding for the 1101-preamble frame link.
package frame_1101_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE = 4'b1101;
  localparam int unsigned PRE_LEN  = 4;

endpackage

// File: rtl/frame_tx_1101_piso_shift.sv
// Parallel-load, MSB-first shift register with clear/load/shift priority.
module piso_shift #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Clear wins over load, load wins over shift.
  always_ff @(posedge clk) begin
    if (clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/frame_tx_1101.sv
// Serial frame transmitter: 1101 preamble, MSB-first payload, forced zero gap.
module frame_tx_1101 #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data,
  output logic              x_out,
  output logic              busy,
  output logic              done
);

  import frame_1101_pkg::*;

  localparam int unsigned MAX_A   = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int unsigned MAX_LEN = (MAX_A > IDLE_GAP) ? MAX_A : IDLE_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             x_n, busy_n, done_n;
  logic             hs, shift, sr_msb;
  logic [1:0]       pre_idx;

  assign start_ready = (state == IDLE) && !rst;
  assign hs          = start_valid && start_ready;

  // Payload holding register; reset clears it, handshake loads it.
  piso_shift #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .clear (rst),
    .load  (hs),
    .shift (shift),
    .din   (data),
    .msb   (sr_msb)
  );

  // Next state plus the line value for the upcoming cycle, so x_out stays registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = 1'b0;
    done_n  = 1'b0;
    shift   = 1'b0;
    pre_idx = 2'd0;
    case (state)
      IDLE: begin
        if (hs) begin
          state_n = PRE;
          cnt_n   = '0;
          x_n     = PREAMBLE[3];
        end
      end
      PRE: begin
        if (cnt == PRE_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          x_n     = sr_msb;
          shift   = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_ONE;
          pre_idx = 2'(PRE_LAST - cnt - CNT_ONE);
          x_n     = PREAMBLE[pre_idx];
        end
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          done_n  = (IDLE_GAP == 1);
        end else begin
          cnt_n = cnt + CNT_ONE;
          x_n   = sr_msb;
          shift = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + CNT_ONE;
          done_n = ((cnt + CNT_ONE) == GAP_LAST);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, counter and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      x_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x_out <= x_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
